// File: rtl/dmem_if.sv
// dmem_if: requester-side bus between a data-memory master (LSU or
// debug/DMA loader) and dmem_arbiter.
//   req    : request, held stable until gnt
//   we     : 1 = store, 0 = load
//   addr   : byte address (bits [1:0] ignored by the arbiter)
//   wdata  : store data, byte lanes aligned to the word
//   be     : store byte enables (ignored for loads)
//   gnt    : request accepted this cycle (combinational)
//   rvalid : one-cycle pulse, load data valid
//   rdata  : load data, held until the next load completes
interface dmem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-only data memory between two
// requesters (m0 = core LSU, m1 = debug/DMA loader).
//   clk, rst      : clock, asynchronous active-high reset
//   m0, m1        : dmem_if slave ports (req/gnt handshake, registered rdata)
//   mem_A         : word-aligned memory address
//   mem_WriteData : memory write data
//   mem_WE        : memory write enable
//   mem_ReadData  : combinational memory read data
// Round-robin arbitration; loads return one cycle after grant. Partial
// stores are turned into a read (grant cycle) followed by a merged word
// write in the RMW_WR cycle, during which no new grant is issued.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_if.slave         m0,
  dmem_if.slave         m1,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WriteData,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_ReadData
);

  localparam logic [AW-1:0] WORD_MASK = ~(AW'(3));

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Per byte lane: take the store lane where enabled, else keep the
  // current memory lane.
  function automatic logic [DW-1:0] byte_merge(
    input logic [DW-1:0] wdata,
    input logic [DW-1:0] rdata,
    input logic [3:0]    be
  );
    logic [DW-1:0] m;
    m = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
    end
    return m;
  endfunction

  state_t        state;
  logic          rr_ptr;
  logic [AW-1:0] rmw_addr_p1;
  logic [DW-1:0] merge_p1;
  logic          m0_vld_p1;
  logic          m1_vld_p1;
  logic [DW-1:0] m0_rdata_p1;
  logic [DW-1:0] m1_rdata_p1;

  logic          idle_p0;
  logic          gnt0_p0;
  logic          gnt1_p0;
  logic          any_gnt_p0;
  logic          sel_we_p0;
  logic [AW-1:0] sel_addr_p0;
  logic [DW-1:0] sel_wdata_p0;
  logic [3:0]    sel_be_p0;
  logic          load_p0;
  logic          full_wr_p0;
  logic          part_wr_p0;

  // ---- p0: arbitration and request select (grant cycle) ----
  // rr_ptr = 0 favours m0 on a tie, 1 favours m1. Reset gates grants so
  // nothing is accepted while rst is held.
  assign idle_p0    = (state == IDLE) && !rst;
  assign gnt0_p0    = idle_p0 && m0.req && (!m1.req || !rr_ptr);
  assign gnt1_p0    = idle_p0 && m1.req && (!m0.req ||  rr_ptr);
  assign any_gnt_p0 = gnt0_p0 || gnt1_p0;

  assign sel_we_p0    = gnt1_p0 ? m1.we    : m0.we;
  assign sel_addr_p0  = gnt1_p0 ? m1.addr  : m0.addr;
  assign sel_wdata_p0 = gnt1_p0 ? m1.wdata : m0.wdata;
  assign sel_be_p0    = gnt1_p0 ? m1.be    : m0.be;

  // be == 0 stores are accepted but touch nothing.
  assign load_p0    = any_gnt_p0 && !sel_we_p0;
  assign full_wr_p0 = any_gnt_p0 && sel_we_p0 && (sel_be_p0 == 4'hF);
  assign part_wr_p0 = any_gnt_p0 && sel_we_p0 &&
                      (sel_be_p0 != 4'hF) && (sel_be_p0 != 4'h0);

  assign m0.gnt = gnt0_p0;
  assign m1.gnt = gnt1_p0;

  // Memory drive: the RMW write owns the port in RMW_WR; otherwise the
  // granted request does. Idle outputs are parked at zero.
  always_comb begin
    mem_A         = '0;
    mem_WriteData = '0;
    mem_WE        = 1'b0;
    if ((state == RMW_WR) && !rst) begin
      mem_A         = rmw_addr_p1;
      mem_WriteData = merge_p1;
      mem_WE        = 1'b1;
    end else if (any_gnt_p0) begin
      mem_A = sel_addr_p0 & WORD_MASK;
      if (full_wr_p0) begin
        mem_WriteData = sel_wdata_p0;
        mem_WE        = 1'b1;
      end
    end
  end

  // ---- p1: registered read response, RMW merge, FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      rmw_addr_p1 <= '0;
      merge_p1    <= '0;
      m0_vld_p1   <= 1'b0;
      m1_vld_p1   <= 1'b0;
      m0_rdata_p1 <= '0;
      m1_rdata_p1 <= '0;
    end else begin
      m0_vld_p1 <= gnt0_p0 && load_p0;
      m1_vld_p1 <= gnt1_p0 && load_p0;
      if (gnt0_p0 && load_p0) m0_rdata_p1 <= mem_ReadData;
      if (gnt1_p0 && load_p0) m1_rdata_p1 <= mem_ReadData;

      // After any grant the other master gets priority on the next tie.
      if (any_gnt_p0) rr_ptr <= gnt0_p0;

      case (state)
        IDLE: begin
          if (part_wr_p0) begin
            merge_p1    <= byte_merge(sel_wdata_p0, mem_ReadData, sel_be_p0);
            rmw_addr_p1 <= sel_addr_p0 & WORD_MASK;
            state       <= RMW_WR;
          end
        end
        RMW_WR: state <= IDLE;
      endcase
    end
  end

  assign m0.rvalid = m0_vld_p1;
  assign m0.rdata  = m0_rdata_p1;
  assign m1.rvalid = m1_vld_p1;
  assign m1.rdata  = m1_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// data_memory, a shadow memory model and per-master load scoreboards.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] mem_A;
  logic [31:0] mem_WriteData;
  logic        mem_WE;
  logic [31:0] mem_ReadData;

  dmem_if #(.AW(32), .DW(32)) m0_bus ();
  dmem_if #(.AW(32), .DW(32)) m1_bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .mem_A         (mem_A),
    .mem_WriteData (mem_WriteData),
    .mem_WE        (mem_WE),
    .mem_ReadData  (mem_ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_memory: combinational read, write on posedge.
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  assign mem_ReadData = mem[mem_A[9:2]];
  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:2]] <= mem_WriteData;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: load data popped per master when rvalid appears; memory
  // address must stay word aligned and inside the modelled range.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_bus.rvalid) begin
        if (q0.size() == 0) check("m0_rvalid_unexpected", 32'd1, 32'd0);
        else                check("m0_rdata", m0_bus.rdata, q0.pop_front());
      end
      if (m1_bus.rvalid) begin
        if (q1.size() == 0) check("m1_rvalid_unexpected", 32'd1, 32'd0);
        else                check("m1_rdata", m1_bus.rdata, q1.pop_front());
      end
      check("mem_A_align", 32'({mem_A[31:10], mem_A[1:0]}), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    if (m == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr;
      m0_bus.wdata = wdata; m0_bus.be = be;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr;
      m1_bus.wdata = wdata; m1_bus.be = be;
    end
  endtask

  task automatic next();
    cyc();
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
  endtask

  // Shadow model update and expected-load push for one accepted request.
  task automatic model(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] mask;
    logic [7:0]  idx;
    idx  = addr[9:2];
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (!we) begin
      if (m == 0) q0.push_back(shadow[idx]);
      else        q1.push_back(shadow[idx]);
    end else begin
      shadow[idx] = (wdata & mask) | (shadow[idx] & ~mask);
    end
  endtask

  // Present a request just after a posedge and wait (bounded) for its
  // grant; returns at the negedge of the grant cycle.
  task automatic issue(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit upd, output int waits);
    logic g;
    g     = 1'b0;
    waits = 0;
    set_bus(m, 1'b1, we, addr, wdata, be);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = (m == 0) ? m0_bus.gnt : m1_bus.gnt;
      if (g) break;
      waits++;
      cyc();
    end
    if (!g) check("gnt_timeout", 32'd0, 32'd1);
    else if (upd) model(m, we, addr, wdata, be);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m0_gnt"},    32'(m0_bus.gnt),    32'd0);
    check({tag, "_m0_rvalid"}, 32'(m0_bus.rvalid), 32'd0);
    check({tag, "_m0_rdata"},  m0_bus.rdata,       32'd0);
    check({tag, "_m1_gnt"},    32'(m1_bus.gnt),    32'd0);
    check({tag, "_m1_rvalid"}, 32'(m1_bus.rvalid), 32'd0);
    check({tag, "_m1_rdata"},  m1_bus.rdata,       32'd0);
    check({tag, "_mem_WE"},    32'(mem_WE),        32'd0);
    check({tag, "_mem_A"},     mem_A,              32'd0);
    check({tag, "_mem_WD"},    mem_WriteData,      32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    mem[8'h04] = 32'h11223344; shadow[8'h04] = 32'h11223344;
    mem[8'h08] = 32'hAABBCCDD; shadow[8'h08] = 32'hAABBCCDD;
    mem[8'h0C] = 32'h12345678; shadow[8'h0C] = 32'h12345678;
    rst = 1'b1;
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state, held then released
    @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");
    cyc();

    // T1: m0 load 0x10
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, w);
    check("t1_gnt_wait", 32'(w), 32'd0);
    check("t1_mem_WE", 32'(mem_WE), 32'd0);
    check("t1_mem_A", mem_A, 32'h10);
    next();
    @(negedge clk);
    check("t1_m0_rvalid", 32'(m0_bus.rvalid), 32'd1);
    cyc();

    // T2: m0 full-word store, then m1 load of the same word back-to-back
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, w);
    check("t2_mem_WE", 32'(mem_WE), 32'd1);
    check("t2_mem_WD", mem_WriteData, 32'hDEADBEEF);
    check("t2_mem_A", mem_A, 32'h10);
    next();
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, w);
    check("t2_ld_gnt_wait", 32'(w), 32'd0);
    check("t2_st_no_rvalid", 32'(m0_bus.rvalid), 32'd0);
    next();
    @(negedge clk);
    check("t2_m1_rvalid", 32'(m1_bus.rvalid), 32'd1);
    check("t2_m0_rvalid", 32'(m0_bus.rvalid), 32'd0);
    cyc();

    // T3: m1 partial store (lane 0) at 0x20 as read-modify-write
    issue(1, 1'b1, 32'h20, 32'h000000EE, 4'b0001, 1'b1, w);
    check("t3_c1_mem_WE", 32'(mem_WE), 32'd0);
    next();
    set_bus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("t3_c2_m0_gnt", 32'(m0_bus.gnt), 32'd0);
    check("t3_c2_mem_WE", 32'(mem_WE), 32'd1);
    check("t3_c2_mem_WD", mem_WriteData, 32'hAABBCCEE);
    check("t3_c2_mem_A", mem_A, 32'h20);
    cyc();
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, w);
    check("t3_m0_after_rmw_wait", 32'(w), 32'd0);
    next();
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, w);
    next();
    @(negedge clk);
    cyc();

    // T4: both masters loading continuously after reset -> alternation
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_bus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_bus(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr_m0_gnt", 32'(m0_bus.gnt), 32'((c % 2) == 0));
      check("rr_m1_gnt", 32'(m1_bus.gnt), 32'((c % 2) == 1));
      if (c > 0) begin
        check("rr_m0_rvalid", 32'(m0_bus.rvalid), 32'((c % 2) == 1));
        check("rr_m1_rvalid", 32'(m1_bus.rvalid), 32'((c % 2) == 0));
      end
      if ((c % 2) == 0) model(0, 1'b0, 32'h10, 32'h0, 4'h0);
      else              model(1, 1'b0, 32'h20, 32'h0, 4'h0);
      cyc();
    end
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
    @(negedge clk);
    cyc();

    // T5: partial store on m0 aborted by reset during RMW_WR
    issue(0, 1'b1, 32'h20, 32'h55000000, 4'b1000, 1'b0, w);
    check("t5_c1_mem_WE", 32'(mem_WE), 32'd0);
    @(posedge clk);
    #2;
    m0_bus.req = 1'b0;
    check("t5_rmw_mem_WE", 32'(mem_WE), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_abort_mem_WE", 32'(mem_WE), 32'd0);
    check("t5_abort_mem_A", mem_A, 32'd0);
    check("t5_abort_mem_WD", mem_WriteData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, w);
    check("t5_idle_gnt_wait", 32'(w), 32'd0);
    next();
    @(negedge clk);
    cyc();

    // T6: be = 0 store is accepted without touching memory
    issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 1'b1, w);
    check("t6_gnt_wait", 32'(w), 32'd0);
    check("t6_mem_WE", 32'(mem_WE), 32'd0);
    next();
    @(negedge clk);
    check("t6_no_rvalid", 32'(m0_bus.rvalid), 32'd0);
    cyc();
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, w);
    next();
    @(negedge clk);
    cyc();

    repeat (2) cyc();
    check("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
